mac_host_driver: RTL
====================

MAC_HOST_DRIVER -- requirements
Module: mac_host_driver

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255: max cycles waited in WAIT_FIN for finish_in.
REQ-002 SHALL have port clock, input, 1: single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset_n, input, 1: asynchronous, active-low reset.
REQ-004 SHALL have ports req_valid (input, 1) and req_ready (output, 1): operand request handshake.
REQ-005 SHALL have ports op_a (input, 8) and op_b (input, 8): operands, sampled on accept.
REQ-006 SHALL have ports ser_a (output, 1) and ser_b (output, 1): serial operand bits to the MAC chip.
REQ-007 SHALL have port start (output, 1): one-cycle start pulse to the MAC chip.
REQ-008 SHALL have ports finish_in (input, 1), res_bit_in (input, 1) and carry_in (input, 1): chip status and serial result.
REQ-009 SHALL have ports rsp_valid (output, 1) and rsp_ready (input, 1): response handshake.
REQ-010 SHALL have ports rsp_result (output, 20), rsp_carry (output, 1) and rsp_error (output, 1): response payload.

Function
REQ-011 FSM states SHALL be IDLE, SHIFT, START, WAIT_FIN, CAPTURE and DONE.
REQ-012 req_ready SHALL equal (state==IDLE); accept SHALL occur when req_valid && req_ready at a clock edge, which loads op_a/op_b into shift registers and enters SHIFT.
REQ-013 SHIFT SHALL last exactly 8 cycles, driving ser_a/ser_b LSB first (bit k in the k-th SHIFT cycle), then enter START.
REQ-014 ser_a and ser_b SHALL be 0 in every state other than SHIFT.
REQ-015 START SHALL last 1 cycle with start=1, then enter WAIT_FIN with the timer cleared; start SHALL be 0 in every other state.
REQ-016 In WAIT_FIN, the first cycle finish_in==1 SHALL sample res_bit_in as result bit 0 and carry_in as rsp_carry, then enter CAPTURE.
REQ-017 CAPTURE SHALL sample res_bit_in on 19 further consecutive cycles as bits 1..19, LSB first, independent of finish_in, then enter DONE.
REQ-018 If WAIT_FIN lasts TIMEOUT cycles with no finish_in, the FSM SHALL enter DONE with rsp_error=1, rsp_result=0 and rsp_carry=0.
REQ-019 DONE SHALL assert rsp_valid and hold the payload stable until rsp_valid && rsp_ready, then return to IDLE.
REQ-020 A new transaction SHALL clear rsp_error.
REQ-021 req_valid SHALL be ignored outside IDLE, and finish_in outside WAIT_FIN.
REQ-022 Latency SHALL be: accept at edge 0; SHIFT cycles 1-8; start in cycle 9; with finish_in first high in cycle F, rsp_valid asserts in cycle F+20.
REQ-023 Response throughput SHALL be at most one transaction in flight.

Reset
REQ-024 reset_n low SHALL immediately force state IDLE; ser_a, ser_b, start, rsp_valid, rsp_result, rsp_carry, rsp_error and all counters to 0; and req_ready to 1.
REQ-025 Reset mid-transaction SHALL abort it with no response; the next accepted request SHALL behave per REQ-022.

Structure
REQ-026 Package mac_link_pkg SHALL hold OP_W=8, RES_W=20 and the FSM state enum.
REQ-027 One sub-module, sipo_shift20 (serial-in parallel-out capture register with shift-enable and clear), SHALL be used for result capture.

Verification
REQ-028 a=8'hA5, b=8'h3C -> ser_a = 1,0,1,0,0,1,0,1 and ser_b = 0,0,1,1,1,1,0,0 over cycles 1-8; start=1 only in cycle 9.
REQ-029 Chip model raises finish 4 cycles after start and streams 20'h0ABCD with carry=0 -> rsp_valid in cycle F+20, rsp_result=20'h0ABCD, rsp_carry=0, rsp_error=0.
REQ-030 Stream 20'hFFFFF with carry=1, and finish_in dropped mid-CAPTURE -> rsp_result=20'hFFFFF, rsp_carry=1.
REQ-031 finish_in never asserted, TIMEOUT=16 -> rsp_valid 16 cycles after entering WAIT_FIN, rsp_error=1, rsp_result=0.
REQ-032 rsp_ready held low 5 cycles with req_valid high throughout -> payload stable, req_ready=0, second request accepted only after the response handshake.
REQ-033 reset_n low in SHIFT cycle 4 -> outputs zero asynchronously and no rsp_valid; a following a=3, b=5 request completes per REQ-022.

Source files
------------

// File: rtl/mac_link_pkg.sv
// Shared widths and FSM state encoding for the MAC chip host-side driver.
package mac_link_pkg;

    localparam int unsigned OP_W  = 8;
    localparam int unsigned RES_W = 20;

    typedef enum logic [2:0] {
        IDLE,
        SHIFT,
        START,
        WAIT_FIN,
        CAPTURE,
        DONE
    } state_t;

endpackage

// File: rtl/sipo_shift20.sv
// Serial-in parallel-out capture register; bits arrive LSB first and settle
// into their final positions after RES_W shifts.
module sipo_shift20
    import mac_link_pkg::*;
(
    input  logic             clock,
    input  logic             reset_n,
    input  logic             clear,
    input  logic             shift_en,
    input  logic             din,
    output logic [RES_W-1:0] q
);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            q <= '0;
        end else if (clear) begin
            q <= '0;
        end else if (shift_en) begin
            q <= {din, q[RES_W-1:1]};
        end
    end

endmodule

// File: rtl/mac_host_driver.sv
// Host-side driver: serialises two operands to the MAC chip, pulses start,
// waits for finish and captures the 20-bit serial result plus carry.
module mac_host_driver
    import mac_link_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [OP_W-1:0]  op_a,
    input  logic [OP_W-1:0]  op_b,
    output logic             ser_a,
    output logic             ser_b,
    output logic             start,
    input  logic             finish_in,
    input  logic             res_bit_in,
    input  logic             carry_in,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [RES_W-1:0] rsp_result,
    output logic             rsp_carry,
    output logic             rsp_error
);

    localparam int unsigned TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

    state_t          state;
    logic [OP_W-1:0] sh_a;
    logic [OP_W-1:0] sh_b;
    logic [4:0]      cnt;
    logic [TW-1:0]   timer;
    logic            accept;
    logic            cap_shift;

    assign req_ready = (state == IDLE);
    assign accept    = req_valid && req_ready;
    // The first finish cycle already carries result bit 0, so capture starts in WAIT_FIN.
    assign cap_shift = ((state == WAIT_FIN) && finish_in) || (state == CAPTURE);

    sipo_shift20 u_capture (
        .clock    (clock),
        .reset_n  (reset_n),
        .clear    (accept),
        .shift_en (cap_shift),
        .din      (res_bit_in),
        .q        (rsp_result)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            sh_a      <= '0;
            sh_b      <= '0;
            cnt       <= '0;
            timer     <= '0;
            ser_a     <= 1'b0;
            ser_b     <= 1'b0;
            start     <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_carry <= 1'b0;
            rsp_error <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        ser_a     <= op_a[0];
                        ser_b     <= op_b[0];
                        sh_a      <= op_a >> 1;
                        sh_b      <= op_b >> 1;
                        cnt       <= '0;
                        rsp_carry <= 1'b0;
                        rsp_error <= 1'b0;
                        state     <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (cnt == 5'(OP_W - 1)) begin
                        ser_a <= 1'b0;
                        ser_b <= 1'b0;
                        start <= 1'b1;
                        state <= START;
                    end else begin
                        ser_a <= sh_a[0];
                        ser_b <= sh_b[0];
                        sh_a  <= sh_a >> 1;
                        sh_b  <= sh_b >> 1;
                        cnt   <= cnt + 5'd1;
                    end
                end
                START: begin
                    start <= 1'b0;
                    timer <= '0;
                    state <= WAIT_FIN;
                end
                WAIT_FIN: begin
                    if (finish_in) begin
                        rsp_carry <= carry_in;
                        cnt       <= '0;
                        state     <= CAPTURE;
                    end else if (timer == TW'(TIMEOUT - 1)) begin
                        rsp_error <= 1'b1;
                        rsp_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                CAPTURE: begin
                    if (cnt == 5'(RES_W - 2)) begin
                        rsp_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        cnt <= cnt + 5'd1;
                    end
                end
                DONE: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
